// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared geometry constants and feeder state encoding
// Purpose: sample/word/window geometry and the line-feeder state type, shared
//          with the interpolation datapath.
// Ports:   none (package).
package interp_pkg;

    localparam int SAMPLE_W     = 8;
    localparam int LINE_SAMPLES = 9;
    localparam int WORD_SAMPLES = 4;
    localparam int ROW_WORDS    = 16;
    localparam int WIN_ROWS     = 9;

    localparam int WORD_W = SAMPLE_W * WORD_SAMPLES;   // 32
    localparam int LINE_W = SAMPLE_W * LINE_SAMPLES;   // 72
    localparam int BUF_W  = WORD_W * 3;                // 96

    localparam logic [3:0] LAST_ROW = 4'(WIN_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        CAP  = 3'd4,
        OUT  = 3'd5
    } feeder_state_t;

endpackage

// File: rtl/line_aligner.sv
// rtl/line_aligner.sv - selects the 9-sample line out of three fetched words
// Purpose: combinational 96-to-72 select; drops X[1:0] leading samples.
// Ports:   i_line_buf - three words, leftmost sample in the top byte
//          i_offset   - sample offset of the window inside the first word
//          o_line     - nine samples, leftmost sample in the top byte
module line_aligner
    import interp_pkg::*;
(
    input  logic [BUF_W-1:0]  i_line_buf,
    input  logic [1:0]        i_offset,
    output logic [LINE_W-1:0] o_line
);

    always_comb begin
        case (i_offset)
            2'd0: o_line = i_line_buf[BUF_W-1              -: LINE_W];
            2'd1: o_line = i_line_buf[BUF_W-1-SAMPLE_W     -: LINE_W];
            2'd2: o_line = i_line_buf[BUF_W-1-2*SAMPLE_W   -: LINE_W];
            2'd3: o_line = i_line_buf[BUF_W-1-3*SAMPLE_W   -: LINE_W];
        endcase
    end

endmodule

// File: rtl/interp_line_feeder.sv
// rtl/interp_line_feeder.sv - fetches a 9x9 sample window line by line
// Purpose: on START, reads three memory words per row, aligns nine samples
//          and hands each row to the consumer with a valid/ready handshake.
// Ports:   CLK, RST (sync, active-high)
//          START, INT_POS_X, INT_POS_Y   - window request and top-left position
//          MEM_RD_EN, MEM_ADDR           - read strobe and word address
//          MEM_RD_DATA                   - read word, one cycle after strobe
//          LINE_VALID, LINE_READY        - line handshake
//          LINE_DATA, LINE_ROW, LINE_LAST - line samples, row index, last flag
//          BUSY, DONE                    - activity and completion pulse
module interp_line_feeder
    import interp_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [5:0]        INT_POS_X,
    input  logic [5:0]        INT_POS_Y,
    output logic              MEM_RD_EN,
    output logic [9:0]        MEM_ADDR,
    input  logic [WORD_W-1:0] MEM_RD_DATA,
    output logic              LINE_VALID,
    input  logic              LINE_READY,
    output logic [LINE_W-1:0] LINE_DATA,
    output logic [3:0]        LINE_ROW,
    output logic              LINE_LAST,
    output logic              BUSY,
    output logic              DONE
);

    feeder_state_t r_state;
    feeder_state_t w_next;

    logic [5:0]          r_x;
    logic [5:0]          r_y;
    logic [3:0]          r_row;
    logic [2*WORD_W-1:0] r_buf;
    logic [LINE_W-1:0]   r_line;
    logic                r_done;

    logic [1:0]          w_word_k;
    logic                w_accept;
    logic [5:0]          w_row_sum;
    logic [9:0]          w_addr;
    logic [BUF_W-1:0]    w_line_buf;
    logic [LINE_W-1:0]   w_aligned;

    // The third word is still on MEM_RD_DATA during CAP, so the full 96-bit
    // line buffer is the two held words plus the live read data.
    assign w_line_buf = {r_buf, MEM_RD_DATA};

    line_aligner u_aligner (
        .i_line_buf (w_line_buf),
        .i_offset   (r_x[1:0]),
        .o_line     (w_aligned)
    );

    assign w_row_sum = r_y + {2'b00, r_row};
    assign w_addr    = {w_row_sum, 4'b0000} + {6'b000000, r_x[5:2]} + {8'b00000000, w_word_k};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        MEM_RD_EN  = 1'b0;
        w_word_k   = 2'd0;
        LINE_VALID = 1'b0;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: if (START) w_next = RD0;
            RD0: begin
                MEM_RD_EN = 1'b1;
                w_word_k  = 2'd0;
                w_next    = RD1;
            end
            RD1: begin
                MEM_RD_EN = 1'b1;
                w_word_k  = 2'd1;
                w_next    = RD2;
            end
            RD2: begin
                MEM_RD_EN = 1'b1;
                w_word_k  = 2'd2;
                w_next    = CAP;
            end
            CAP: w_next = OUT;
            OUT: begin
                LINE_VALID = 1'b1;
                if (LINE_READY) begin
                    w_accept = 1'b1;
                    w_next   = (r_row == LAST_ROW) ? IDLE : RD0;
                end
            end
            default: w_next = IDLE;
        endcase
        MEM_ADDR  = MEM_RD_EN ? w_addr : 10'd0;
        LINE_LAST = LINE_VALID && (r_row == LAST_ROW);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x    <= 6'd0;
            r_y    <= 6'd0;
            r_row  <= 4'd0;
            r_buf  <= '0;
            r_line <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_accept && (r_row == LAST_ROW);
            if (r_state == IDLE && START) begin
                r_x   <= INT_POS_X;
                r_y   <= INT_POS_Y;
                r_row <= 4'd0;
            end
            // Words arrive left to right; shift each into the low end.
            if (r_state == RD1 || r_state == RD2) begin
                r_buf <= {r_buf[WORD_W-1:0], MEM_RD_DATA};
            end
            if (r_state == CAP) begin
                r_line <= w_aligned;
            end
            if (w_accept && r_row != LAST_ROW) begin
                r_row <= r_row + 4'd1;
            end
        end
    end

    assign LINE_DATA = r_line;
    assign LINE_ROW  = r_row;
    assign BUSY      = (r_state != IDLE);
    assign DONE      = r_done;

endmodule

// File: tb/tb_interp_line_feeder.sv
// tb/tb_interp_line_feeder.sv - directed scoreboard bench for interp_line_feeder
module tb_interp_line_feeder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [5:0]  INT_POS_X = 6'd0;
    logic [5:0]  INT_POS_Y = 6'd0;
    logic        MEM_RD_EN;
    logic [9:0]  MEM_ADDR;
    logic [31:0] MEM_RD_DATA = 32'd0;
    logic        LINE_VALID;
    logic        LINE_READY = 1'b1;
    logic [71:0] LINE_DATA;
    logic [3:0]  LINE_ROW;
    logic        LINE_LAST;
    logic        BUSY;
    logic        DONE;

    interp_line_feeder dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .INT_POS_X   (INT_POS_X),
        .INT_POS_Y   (INT_POS_Y),
        .MEM_RD_EN   (MEM_RD_EN),
        .MEM_ADDR    (MEM_ADDR),
        .MEM_RD_DATA (MEM_RD_DATA),
        .LINE_VALID  (LINE_VALID),
        .LINE_READY  (LINE_READY),
        .LINE_DATA   (LINE_DATA),
        .LINE_ROW    (LINE_ROW),
        .LINE_LAST   (LINE_LAST),
        .BUSY        (BUSY),
        .DONE        (DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(logic [9:0] a);
        logic [31:0] w;
        int row, wc;
        row = int'(a) / 16;
        wc  = int'(a) % 16;
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((row*64 + wc*4 + j) % 256);
        return w;
    endfunction

    // Registered memory: data one cycle after the strobe, junk otherwise.
    always @(posedge CLK) begin
        if (MEM_RD_EN) MEM_RD_DATA <= mem_word(MEM_ADDR);
        else           MEM_RD_DATA <= 32'hDEADBEEF;
    end

    function automatic logic [71:0] line_of(int x, int y, int r);
        logic [71:0] d;
        for (int i = 0; i < 9; i++) d[71-8*i -: 8] = 8'(((y + r)*64 + x + i) % 256);
        return d;
    endfunction

    typedef struct packed {
        logic [71:0] data;
        logic [3:0]  row;
        logic        last;
    } line_t;

    line_t sb[$];
    int    addr_log[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    t_start = 0;
    int    k_ready = 0;

    task automatic check(string tag, logic [71:0] obs, logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Inspects the values the coming rising edge will sample, then advances
    // to the next falling edge.
    task automatic tick();
        line_t e;
        if (!RST) begin
            if (MEM_RD_EN) addr_log.push_back(int'(MEM_ADDR));
            else check("addr_zero_when_idle", MEM_ADDR, 0);
            if (LINE_VALID) check("rd_en_while_valid", MEM_RD_EN, 0);
            if (LINE_VALID && LINE_READY) begin
                check("line_expected", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("line_row", LINE_ROW, e.row);
                    check("line_data", LINE_DATA, e.data);
                    check("line_last", LINE_LAST, e.last);
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic start_window(int x, int y);
        INT_POS_X = 6'(x);
        INT_POS_Y = 6'(y);
        START     = 1'b1;
        t_start   = cyc;
        addr_log.delete();
        for (int r = 0; r < 9; r++) sb.push_back('{data: line_of(x, y, r), row: 4'(r), last: (r == 8)});
        tick();
        START = 1'b0;
    endtask

    task automatic wait_valid(int exp_cycle);
        for (int i = 0; i < 100 && !LINE_VALID; i++) tick();
        check("first_valid_cycle", cyc, exp_cycle);
    endtask

    task automatic wait_done(int exp_cycle);
        for (int i = 0; i < 200 && !DONE; i++) tick();
        check("done_cycle", cyc, exp_cycle);
        check("sb_drained", sb.size(), 0);
        check("busy_at_done", BUSY, 0);
    endtask

    initial begin
        // Reset state
        RST = 1'b1;
        @(negedge CLK);
        tick();
        tick();
        check("rst_rd_en", MEM_RD_EN, 0);
        check("rst_addr", MEM_ADDR, 0);
        check("rst_valid", LINE_VALID, 0);
        check("rst_data", LINE_DATA, 0);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        RST = 1'b0;
        tick();
        check("idle_busy", BUSY, 0);

        // X=0, Y=0, ready held high
        start_window(0, 0);
        wait_valid(t_start + 5);
        check("a_row0_data", LINE_DATA, 72'h000102030405060708);
        wait_done(t_start + 46);

        // X=5, Y=2 started in the same cycle as DONE
        start_window(5, 2);
        wait_valid(t_start + 5);
        check("b_row0_data", LINE_DATA, 72'h85868788898A8B8C8D);
        for (int i = 0; i < 100 && !LINE_LAST; i++) tick();
        check("b_last_row", LINE_ROW, 8);
        check("b_last_first_byte", LINE_DATA[71:64], 8'h85);
        wait_done(t_start + 46);
        check("b_addr_count", addr_log.size(), 27);
        check("b_addr0", addr_log[0], 33);
        check("b_addr1", addr_log[1], 34);
        check("b_addr2", addr_log[2], 35);
        tick();
        tick();

        // X=55, Y=55: bottom-right corner of memory
        start_window(55, 55);
        wait_done(t_start + 46);
        check("c_addr_count", addr_log.size(), 27);
        check("c_addr0", addr_log[0], 893);
        check("c_addr1", addr_log[1], 894);
        check("c_addr2", addr_log[2], 895);
        check("c_addr24", addr_log[24], 1021);
        check("c_addr26", addr_log[26], 1023);
        tick();

        // Back-pressure at row 3
        start_window(3, 7);
        for (int i = 0; i < 100 && LINE_ROW != 4'd3; i++) tick();
        LINE_READY = 1'b0;
        for (int i = 0; i < 100 && !LINE_VALID; i++) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", LINE_VALID, 1);
            check("stall_data", LINE_DATA, line_of(3, 7, 3));
            check("stall_row", LINE_ROW, 3);
            check("stall_rd_en", MEM_RD_EN, 0);
        end
        LINE_READY = 1'b1;
        k_ready = cyc;
        tick();
        for (int i = 0; i < 100 && !(LINE_VALID && LINE_ROW == 4'd4); i++) tick();
        check("stall_row4_cycle", cyc, k_ready + 5);
        wait_done(k_ready + 26);
        tick();

        // START while busy is ignored; reset in the middle of row 4
        start_window(10, 20);
        tick();
        tick();
        INT_POS_X = 6'd0;
        INT_POS_Y = 6'd0;
        START = 1'b1;
        tick();
        START = 1'b0;
        for (int i = 0; i < 100 && !(LINE_VALID && LINE_ROW == 4'd4); i++) tick();
        check("e_row4_data", LINE_DATA, line_of(10, 20, 4));
        RST = 1'b1;
        tick();
        check("e_rst_rd_en", MEM_RD_EN, 0);
        check("e_rst_addr", MEM_ADDR, 0);
        check("e_rst_valid", LINE_VALID, 0);
        check("e_rst_data", LINE_DATA, 0);
        check("e_rst_row", LINE_ROW, 0);
        check("e_rst_last", LINE_LAST, 0);
        check("e_rst_busy", BUSY, 0);
        check("e_rst_done", DONE, 0);
        RST = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            tick();
            check("e_quiet_valid", LINE_VALID, 0);
        end
        start_window(1, 0);
        wait_valid(t_start + 5);
        check("e_restart_row", LINE_ROW, 0);
        wait_done(t_start + 46);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
